// File: rtl/writeback_stage_pl.sv
// rtl/writeback_stage_pl.sv - RV32I writeback stage with one pipeline register
//
// Purpose:
//   Takes one retiring instruction per cycle over a valid/ready handshake and holds it
//   in a single pipeline register. From that register it decides whether the instruction
//   writes a register, aligns and extends load data, and drives the register-bank write
//   port and a forwarding tap.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   in_valid/ready  upstream handshake; in_ready = ~vld | ~stall
//   instruction     32-bit instruction word of the retiring instruction
//   alu_result      ALU result or load effective address
//   mem_rdata       raw aligned-word load data
//   pc_plus4        link value for JAL/JALR
//   stall           register bank busy; hold the current entry
//   w_en, rd, w_data  register-bank write port
//   fwd_valid       forwarding tap valid (same as w_en)
//   misalign        one-cycle pulse when a misaligned load leaves without writing
//   retired_count   retired-instruction counter (only with RETIRE_CNT_EN)
//
// Configuration macro: RETIRE_CNT_EN adds the retired_count port and counter.

module writeback_stage_pl #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 32,
  localparam int RD_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic             stall,
  output logic             w_en,
  output logic [RD_W-1:0]  rd,
  output logic [XLEN-1:0]  w_data,
  output logic             fwd_valid,
`ifdef RETIRE_CNT_EN
  output logic [CNT_W-1:0] retired_count,
`endif
  output logic             misalign
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Only opcode, funct3 and rd are needed downstream, so only those fields are stored.
  logic                vld_q, vld_d;
  logic [6:0]          opcode_q, opcode_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [RD_W-1:0]     rd_q, rd_d;
  logic [XLEN-1:0]     alu_q, alu_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic [XLEN-1:0]     link_q, link_d;

  logic                accept;
  logic                leave;
  logic                is_load;
  logic                is_link;
  logic                writes;
  logic                load_misaligned;
  logic [31:0]         ld_word;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [XLEN-1:0]     ld_value;

  logic                unused_instr_hi;
  assign unused_instr_hi = ^instruction[31:15];

  assign in_ready = ~vld_q | ~stall;
  assign accept   = in_valid & in_ready;
  // An entry leaves the stage on every non-stalled cycle, whether or not it writes.
  assign leave    = vld_q & ~stall;

  always_comb begin
    vld_d    = vld_q;
    opcode_d = opcode_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    alu_d    = alu_q;
    rdata_d  = rdata_q;
    link_d   = link_q;
    if (in_ready) begin
      vld_d = in_valid;
    end
    if (accept) begin
      opcode_d = instruction[6:0];
      funct3_d = instruction[14:12];
      rd_d     = instruction[7 +: RD_W];
      alu_d    = alu_result;
      rdata_d  = mem_rdata;
      link_d   = pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q    <= 1'b0;
      opcode_q <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      alu_q    <= '0;
      rdata_q  <= '0;
      link_q   <= '0;
    end else begin
      vld_q    <= vld_d;
      opcode_q <= opcode_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      alu_q    <= alu_d;
      rdata_q  <= rdata_d;
      link_q   <= link_d;
    end
  end

  always_comb begin
    is_load = (opcode_q == OP_LOAD);
    is_link = (opcode_q == OP_JAL) || (opcode_q == OP_JALR);
    writes  = is_load || is_link || (opcode_q == OP_IMM) || (opcode_q == OP_REG) ||
              (opcode_q == OP_LUI) || (opcode_q == OP_AUIPC);
  end

  // Load alignment: memory returns the whole aligned word; the low address bits pick
  // the byte or halfword lane.
  always_comb begin
    ld_word = rdata_q[31:0];
    case (alu_q[1:0])
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = alu_q[1] ? ld_word[31:16] : ld_word[15:0];

    load_misaligned = 1'b0;
    case (funct3_q)
      F3_LH, F3_LHU: load_misaligned = is_load & alu_q[0];
      F3_LW:         load_misaligned = is_load & (alu_q[1:0] != 2'b00);
      default:       load_misaligned = 1'b0;
    endcase

    case (funct3_q)
      F3_LB:   ld_value = XLEN'(signed'(ld_byte));
      F3_LBU:  ld_value = XLEN'(ld_byte);
      F3_LH:   ld_value = XLEN'(signed'(ld_half));
      F3_LHU:  ld_value = XLEN'(ld_half);
      default: ld_value = XLEN'(signed'(ld_word));
    endcase
  end

  // Outputs come straight from the pipeline register, so they stay stable under stall
  // and clear immediately on reset.
  always_comb begin
    w_en     = leave & writes & (rd_q != '0) & ~load_misaligned;
    misalign = leave & load_misaligned;
    rd       = rd_q;
    if (is_load) begin
      w_data = ld_value;
    end else if (is_link) begin
      w_data = link_q;
    end else begin
      w_data = alu_q;
    end
  end

  assign fwd_valid = w_en;

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (leave) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retired_count = cnt_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule
